mig_mem_responder: RTL and testbench

Memory-side responder for the MIG CPU instruction-fetch read interface. It accepts word read requests from the IFU's `read_request`/`read_addr` pair and returns one word per request after a fixed configurable latency. It pulses `read_data_ready` together with `read_data`. It holds a word-addressed storage array with a backdoor load port for bench/boot preload, and sits at the memory end of the CPU's `mem_read_*` bus.

---
 rtl/mig_mem_responder_if.sv | 22 ++
 rtl/mig_mem_responder.sv | 116 +++++++++++
 tb/tb_mig_mem_responder.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mig_mem_responder_if.sv
// Instruction-fetch read bus between the IFU (master) and the memory responder (slave).
interface mig_mem_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32
);
  logic                  read_request;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic                  read_data_ready;
  logic [WORD_WIDTH-1:0] read_data;
  logic                  read_error;
  logic                  busy;

  modport master (
    output read_request, read_addr,
    input  read_data_ready, read_data, read_error, busy
  );

  modport slave (
    input  read_request, read_addr,
    output read_data_ready, read_data, read_error, busy
  );
endinterface

// File: rtl/mig_mem_responder.sv
// Fixed-latency word-read responder with backdoor preload for the MIG instruction-fetch bus.
// Define MIG_MEM_RESP_ADDR_CHECK_EN to flag misaligned / out-of-range reads via read_error.
module mig_mem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_SIZE  = 4,
  parameter int WORD_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  mig_mem_responder_if.slave       bus,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_index,
  input  logic [WORD_WIDTH-1:0]    load_data
);
  localparam int         OFF_W     = $clog2(WORD_SIZE);
  localparam int         IDX_W     = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = 4'(LATENCY - 2);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic [IDX_W-1:0]      idx_q;
  logic                  err_q;
  logic [WORD_WIDTH-1:0] mem [DEPTH];

  logic                  acc_err;
  logic [IDX_W-1:0]      fetch_idx;
  logic                  fetch_err;
  logic                  enter_resp;

  function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_WIDTH-1:0] addr);
    return addr[OFF_W +: IDX_W];
  endfunction

`ifdef MIG_MEM_RESP_ADDR_CHECK_EN
  function automatic logic addr_error(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off_mask;
    off_mask = ADDR_WIDTH'(WORD_SIZE - 1);
    return ((addr & off_mask) != '0) || (64'(addr) >= 64'(DEPTH) * 64'(WORD_SIZE));
  endfunction

  assign acc_err = addr_error(bus.read_addr);
`else
  logic unused_addr_bits;
  assign acc_err          = 1'b0;
  assign unused_addr_bits = ^bus.read_addr;
`endif

  // In IDLE the fetch target comes straight from the bus (LATENCY=1 fetches on the accept edge).
  always_comb begin
    fetch_idx = idx_q;
    fetch_err = err_q;
    if (state == IDLE) begin
      fetch_idx = word_index(bus.read_addr);
      fetch_err = acc_err;
    end
  end

  assign enter_resp = ((state == IDLE) && bus.read_request && (LATENCY == 1)) ||
                      ((state == WAIT) && (cnt == '0));

  // Storage has no reset; preload happens through the backdoor port.
  always_ff @(posedge clk) begin
    if (load_en) mem[load_index] <= load_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state               <= IDLE;
      cnt                 <= '0;
      idx_q               <= '0;
      err_q               <= 1'b0;
      bus.read_data_ready <= 1'b0;
      bus.read_data       <= '0;
      bus.read_error      <= 1'b0;
      bus.busy            <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.read_request) begin
            idx_q    <= fetch_idx;
            err_q    <= fetch_err;
            bus.busy <= 1'b1;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) state <= RESP;
          else           cnt   <= cnt - 4'd1;
        end
        RESP: begin
          state               <= IDLE;
          bus.read_data_ready <= 1'b0;
          bus.read_error      <= 1'b0;
          bus.busy            <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      // Nonblocking read of mem gives read-before-write against a same-edge backdoor load.
      if (enter_resp) begin
        bus.read_data_ready <= 1'b1;
        bus.read_error      <= fetch_err;
        bus.read_data       <= fetch_err ? '1 : mem[fetch_idx];
      end
    end
  end
endmodule

// File: tb/tb_mig_mem_responder.sv
// Directed bench for mig_mem_responder: one instance at LATENCY=2 and one at LATENCY=1.
module tb_mig_mem_responder;
  localparam int AW = 32;
  localparam int WW = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_en = 1'b0;
  logic [9:0]  load_index = '0;
  logic [31:0] load_data = '0;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  mig_mem_responder_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) bus2 ();
  mig_mem_responder_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) bus1 ();

  mig_mem_responder #(.ADDR_WIDTH(AW), .WORD_SIZE(4), .WORD_WIDTH(WW), .DEPTH(1024), .LATENCY(2)) u_lat2 (
    .clk(clk), .reset(reset), .bus(bus2.slave),
    .load_en(load_en), .load_index(load_index), .load_data(load_data));

  mig_mem_responder #(.ADDR_WIDTH(AW), .WORD_SIZE(4), .WORD_WIDTH(WW), .DEPTH(1024), .LATENCY(1)) u_lat1 (
    .clk(clk), .reset(reset), .bus(bus1.slave),
    .load_en(load_en), .load_index(load_index), .load_data(load_data));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load(input int idx, input logic [31:0] d);
    load_en    = 1'b1;
    load_index = idx[9:0];
    load_data  = d;
    tick();
    load_en    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus2.read_request = 1'b0; bus2.read_addr = '0;
    bus1.read_request = 1'b0; bus1.read_addr = '0;

    // Reset values
    tick(); tick();
    chk("rst_rdy2",  bus2.read_data_ready, 0);
    chk("rst_data2", bus2.read_data, 0);
    chk("rst_err2",  bus2.read_error, 0);
    chk("rst_busy2", bus2.busy, 0);
    chk("rst_rdy1",  bus1.read_data_ready, 0);
    chk("rst_busy1", bus1.busy, 0);
    reset = 1'b1;
    repeat (3) begin
      tick();
      chk("idle_rdy",  bus2.read_data_ready, 0);
      chk("idle_busy", bus2.busy, 0);
      chk("idle_data", bus2.read_data, 0);
    end

    load(0, 32'hA0A0_0000);
    load(1, 32'hB1B1_1111);
    load(3, 32'h1122_3344);
    load(5, 32'h0000_0000);
    load(7, 32'h7777_7777);

    // Basic read, LATENCY=2
    bus2.read_request = 1'b1; bus2.read_addr = 32'h0C;
    tick();
    bus2.read_request = 1'b0;
    chk("basic_wait_rdy",  bus2.read_data_ready, 0);
    chk("basic_wait_busy", bus2.busy, 1);
    tick();
    chk("basic_rdy",  bus2.read_data_ready, 1);
    chk("basic_data", bus2.read_data, 32'h1122_3344);
    chk("basic_err",  bus2.read_error, 0);
    tick();
    chk("basic_after_rdy",  bus2.read_data_ready, 0);
    chk("basic_after_busy", bus2.busy, 0);
    repeat (8) tick();
    chk("basic_hold_data", bus2.read_data, 32'h1122_3344);

    // Address change during WAIT is ignored
    bus2.read_request = 1'b1; bus2.read_addr = 32'h1C;
    tick();
    bus2.read_request = 1'b0; bus2.read_addr = 32'h0;
    tick();
    chk("capt_rdy",  bus2.read_data_ready, 1);
    chk("capt_data", bus2.read_data, 32'h7777_7777);
    tick();

    // Held request, LATENCY=1: responses one word every two cycles
    bus1.read_request = 1'b1; bus1.read_addr = 32'h0;
    tick();
    chk("held_rdy0",  bus1.read_data_ready, 1);
    chk("held_data0", bus1.read_data, 32'hA0A0_0000);
    chk("held_busy0", bus1.busy, 1);
    bus1.read_addr = 32'h4;
    tick();
    chk("held_gap_rdy",  bus1.read_data_ready, 0);
    chk("held_gap_busy", bus1.busy, 0);
    tick();
    chk("held_rdy1",  bus1.read_data_ready, 1);
    chk("held_data1", bus1.read_data, 32'hB1B1_1111);
    bus1.read_request = 1'b0;
    tick();
    chk("held_end_rdy", bus1.read_data_ready, 0);

    // Backdoor load collides with the fetch of index 5
    bus2.read_request = 1'b1; bus2.read_addr = 32'h14;
    tick();
    bus2.read_request = 1'b0;
    load_en = 1'b1; load_index = 10'd5; load_data = 32'hAAAA_5555;
    tick();
    load_en = 1'b0;
    chk("coll_rdy",  bus2.read_data_ready, 1);
    chk("coll_data", bus2.read_data, 32'h0);
    tick();
    bus2.read_request = 1'b1; bus2.read_addr = 32'h14;
    tick();
    bus2.read_request = 1'b0;
    tick();
    chk("coll_rpt_rdy",  bus2.read_data_ready, 1);
    chk("coll_rpt_data", bus2.read_data, 32'hAAAA_5555);
    tick();

    // Reset during WAIT drops the request
    bus2.read_request = 1'b1; bus2.read_addr = 32'h0C;
    tick();
    bus2.read_request = 1'b0;
    chk("rstw_busy_pre", bus2.busy, 1);
    reset = 1'b0;
    #1;
    chk("rstw_busy",  bus2.busy, 0);
    chk("rstw_rdy",   bus2.read_data_ready, 0);
    chk("rstw_data",  bus2.read_data, 0);
    tick();
    reset = 1'b1;
    repeat (3) begin
      tick();
      chk("rstw_no_resp", bus2.read_data_ready, 0);
    end
    bus2.read_request = 1'b1; bus2.read_addr = 32'h1C;
    tick();
    bus2.read_request = 1'b0;
    tick();
    chk("rstw_new_rdy",  bus2.read_data_ready, 1);
    chk("rstw_new_data", bus2.read_data, 32'h7777_7777);
    tick();
    chk("rstw_new_busy", bus2.busy, 0);

    // Misaligned address
    bus2.read_request = 1'b1; bus2.read_addr = 32'h2;
    tick();
    bus2.read_request = 1'b0;
    tick();
    chk("mis_rdy", bus2.read_data_ready, 1);
`ifdef MIG_MEM_RESP_ADDR_CHECK_EN
    chk("mis_err",  bus2.read_error, 1);
    chk("mis_data", bus2.read_data, 32'hFFFF_FFFF);
`else
    chk("mis_err",  bus2.read_error, 0);
    chk("mis_data", bus2.read_data, 32'hA0A0_0000);
`endif
    tick();
    chk("mis_err_clear", bus2.read_error, 0);

    // Out-of-range address
    bus2.read_request = 1'b1; bus2.read_addr = 32'h1000;
    tick();
    bus2.read_request = 1'b0;
    tick();
    chk("oor_rdy", bus2.read_data_ready, 1);
`ifdef MIG_MEM_RESP_ADDR_CHECK_EN
    chk("oor_err",  bus2.read_error, 1);
    chk("oor_data", bus2.read_data, 32'hFFFF_FFFF);
`else
    chk("oor_err",  bus2.read_error, 0);
    chk("oor_data", bus2.read_data, 32'hA0A0_0000);
`endif
    tick();
    chk("oor_err_clear", bus2.read_error, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
